// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and response-slot type for the data-memory arbiter
package dmem_pkg;

  // Access size encodings; 2'd3 is reserved and always rejected.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Requester identifiers.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Single registered response slot.
  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } rsp_slot_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - byte-lane strobe, write-data replication and alignment check
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  // Decode size and low address bits into strobes, replicated data and legality.
  always_comb begin
    wstrb      = 4'b0000;
    wdata_rep  = 32'h0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        wstrb      = 4'b1111;
        wdata_rep  = wdata;
        misaligned = |addr_lo;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter and access controller for the data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  rsp_slot_t         rsp_q, rsp_d;
  logic              last_gnt_q, last_gnt_d;

  logic              cpu_ok, dbg_ok;
  logic              gnt_any, gnt_id;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        fmt_wstrb;
  logic [31:0]       fmt_wdata;
  logic              fmt_mis;

  // Pick at most one winner; ties go to whoever was not granted last, lock masks the CPU.
  always_comb begin
    cpu_ok  = cpu_req & ~dbg_lock & ~rst;
    dbg_ok  = dbg_req & ~rst;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (cpu_ok && dbg_ok) begin
      if (last_gnt_q == REQ_CPU) dbg_gnt = 1'b1;
      else                       cpu_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_ok;
      dbg_gnt = dbg_ok;
    end
    gnt_any = cpu_gnt | dbg_gnt;
    gnt_id  = dbg_gnt ? REQ_DBG : REQ_CPU;
  end

  // Route the winner's payload to the single lane formatter.
  always_comb begin
    sel_we    = dbg_gnt ? dbg_we    : cpu_we;
    sel_size  = dbg_gnt ? dbg_size  : cpu_size;
    sel_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    sel_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
  end

  dmem_lane_fmt u_lane_fmt (
    .size       (sel_size),
    .addr_lo    (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .wstrb      (fmt_wstrb),
    .wdata_rep  (fmt_wdata),
    .misaligned (fmt_mis)
  );

  // Drive the memory port only for a legal granted access; everything else is zero.
  always_comb begin
    mem_en    = gnt_any & ~fmt_mis;
    mem_we    = mem_en & sel_we;
    mem_wstrb = mem_we ? fmt_wstrb : 4'b0000;
    mem_addr  = mem_en ? sel_addr[ADDR_W-1:2] : '0;
    mem_wdata = mem_we ? fmt_wdata : 32'h0;
  end

  // Next response slot: loads and rejected accesses answer; clean stores do not.
  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = gnt_any & (fmt_mis | ~sel_we);
    rsp_d.owner = gnt_id;
    rsp_d.err   = fmt_mis;
    last_gnt_d  = gnt_any ? gnt_id : last_gnt_q;
  end

  // Response slot and round-robin history; reset favours the CPU on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q      <= '0;
      last_gnt_q <= REQ_DBG;
    end else begin
      rsp_q      <= rsp_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Steer the registered response to its owner; errors return zero data.
  always_comb begin
    cpu_rvalid = rsp_q.valid & (rsp_q.owner == REQ_CPU);
    dbg_rvalid = rsp_q.valid & (rsp_q.owner == REQ_DBG);
    cpu_err    = cpu_rvalid & rsp_q.err;
    dbg_err    = dbg_rvalid & rsp_q.err;
    cpu_rdata  = (cpu_rvalid && !rsp_q.err) ? mem_rdata : 32'h0;
    dbg_rdata  = (dbg_rvalid && !rsp_q.err) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [1:0]        cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0]       cpu_rdata;
  logic              dbg_req, dbg_we;
  logic [1:0]        dbg_size;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0]       dbg_rdata;
  logic              dbg_lock;
  logic              mem_en, mem_we;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  logic [31:0] mem_model [0:255];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_size   (cpu_size),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_size   (dbg_size),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .dbg_err    (dbg_err),
    .dbg_lock   (dbg_lock),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port memory with byte strobes, read-before-write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [1:0] size,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [1:0] size,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    dbg_req = req; dbg_we = we; dbg_size = size; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, SZ_BYTE, '0, 32'h0);
    set_dbg(1'b0, 1'b0, SZ_BYTE, '0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
    rst = 1'b1;
    dbg_lock = 1'b0;
    idle();

    // Reset and idle
    @(negedge clk);
    @(negedge clk); #1;
    check("rst_cpu_gnt",    cpu_gnt,    0);
    check("rst_dbg_gnt",    dbg_gnt,    0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_cpu_err",    cpu_err,    0);
    check("rst_dbg_err",    dbg_err,    0);
    check("rst_mem_en",     mem_en,     0);
    check("rst_mem_we",     mem_we,     0);
    check("rst_mem_wstrb",  mem_wstrb,  0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_wdata",  mem_wdata,  0);
    @(negedge clk); rst = 1'b0; #1;
    check("idle_mem_en",     mem_en,     0);
    check("idle_cpu_rvalid", cpu_rvalid, 0);

    // Word store then word load
    @(negedge clk); set_cpu(1'b1, 1'b1, SZ_WORD, 10'h010, 32'hDEADBEEF); #1;
    check("st_gnt",   cpu_gnt,   1);
    check("st_en",    mem_en,    1);
    check("st_we",    mem_we,    1);
    check("st_addr",  mem_addr,  4);
    check("st_wstrb", mem_wstrb, 4'b1111);
    check("st_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); set_cpu(1'b1, 1'b0, SZ_WORD, 10'h010, 32'h0); #1;
    check("ld_gnt",        cpu_gnt,    1);
    check("ld_en",         mem_en,     1);
    check("ld_we",         mem_we,     0);
    check("ld_wstrb",      mem_wstrb,  0);
    check("st_no_rvalid",  cpu_rvalid, 0);
    @(negedge clk); idle(); #1;
    check("ld_rvalid",     cpu_rvalid, 1);
    check("ld_rdata",      cpu_rdata,  32'hDEADBEEF);
    check("ld_err",        cpu_err,    0);
    check("ld_dbg_rvalid", dbg_rvalid, 0);

    // Byte and half lanes
    @(negedge clk); set_cpu(1'b1, 1'b1, SZ_BYTE, 10'h013, 32'h123456AB); #1;
    check("sb_wstrb", mem_wstrb, 4'b1000);
    check("sb_wdata", mem_wdata, 32'hABABABAB);
    check("sb_addr",  mem_addr,  4);
    @(negedge clk); set_cpu(1'b1, 1'b1, SZ_HALF, 10'h012, 32'hFFFF5678); #1;
    check("sh_wstrb", mem_wstrb, 4'b1100);
    check("sh_wdata", mem_wdata, 32'h56785678);
    @(negedge clk); set_cpu(1'b1, 1'b0, SZ_BYTE, 10'h011, 32'hFFFFFFFF); #1;
    check("lb_wstrb", mem_wstrb, 0);
    check("lb_wdata", mem_wdata, 0);
    check("lb_addr",  mem_addr,  4);
    @(negedge clk); idle(); #1;
    check("lb_rdata", cpu_rdata, 32'h5678BEEF);

    // Misaligned and illegal accesses
    @(negedge clk); set_cpu(1'b1, 1'b0, SZ_WORD, 10'h006, 32'h0); #1;
    check("mis_ld_gnt", cpu_gnt, 1);
    check("mis_ld_en",  mem_en,  0);
    @(negedge clk); set_cpu(1'b1, 1'b1, SZ_HALF, 10'h001, 32'h00001111); #1;
    check("mis_ld_rvalid", cpu_rvalid, 1);
    check("mis_ld_err",    cpu_err,    1);
    check("mis_ld_rdata",  cpu_rdata,  0);
    check("mis_st_gnt",    cpu_gnt,    1);
    check("mis_st_en",     mem_en,     0);
    check("mis_st_we",     mem_we,     0);
    @(negedge clk); set_cpu(1'b1, 1'b0, 2'd3, 10'h000, 32'h0); #1;
    check("mis_st_rvalid", cpu_rvalid, 1);
    check("mis_st_err",    cpu_err,    1);
    check("sz3_en",        mem_en,     0);
    @(negedge clk); idle(); #1;
    check("sz3_rvalid", cpu_rvalid, 1);
    check("sz3_err",    cpu_err,    1);
    @(negedge clk); #1;
    check("rsp_cleared", cpu_rvalid, 0);
    check("err_cleared", cpu_err,    0);

    // Contention from reset: CPU, dbg, CPU, dbg
    @(negedge clk); rst = 1'b1;
    set_cpu(1'b1, 1'b0, SZ_WORD, 10'h010, 32'h0);
    set_dbg(1'b1, 1'b0, SZ_WORD, 10'h010, 32'h0); #1;
    check("rstreq_cpu_gnt", cpu_gnt, 0);
    check("rstreq_dbg_gnt", dbg_gnt, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rr1_cpu", cpu_gnt, 1);
    check("rr1_dbg", dbg_gnt, 0);
    @(negedge clk); #1;
    check("rr2_cpu",        cpu_gnt,    0);
    check("rr2_dbg",        dbg_gnt,    1);
    check("rr2_cpu_rvalid", cpu_rvalid, 1);
    check("rr2_cpu_rdata",  cpu_rdata,  32'h5678BEEF);
    check("rr2_dbg_rvalid", dbg_rvalid, 0);
    check("rr2_dbg_rdata",  dbg_rdata,  0);
    @(negedge clk); #1;
    check("rr3_cpu",        cpu_gnt,    1);
    check("rr3_dbg_rvalid", dbg_rvalid, 1);
    check("rr3_dbg_rdata",  dbg_rdata,  32'h5678BEEF);
    check("rr3_cpu_rvalid", cpu_rvalid, 0);
    check("rr3_cpu_rdata",  cpu_rdata,  0);
    @(negedge clk); #1;
    check("rr4_dbg", dbg_gnt, 1);

    // Lock: only dbg wins while held; CPU wins the cycle it drops
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dbg_lock = 1'b1; #1;
      check("lock_cpu_gnt", cpu_gnt, 0);
      check("lock_dbg_gnt", dbg_gnt, 1);
    end
    @(negedge clk); dbg_lock = 1'b0; #1;
    check("unlock_cpu_gnt", cpu_gnt, 1);
    check("unlock_dbg_gnt", dbg_gnt, 0);
    @(negedge clk); dbg_lock = 1'b1; #1;
    check("lockrise_cpu_rvalid", cpu_rvalid, 1);
    check("lockrise_cpu_gnt",    cpu_gnt,    0);
    @(negedge clk); dbg_lock = 1'b0; idle();

    // Reset mid-load drops the response and restores the CPU tie preference
    @(negedge clk); set_dbg(1'b1, 1'b0, SZ_WORD, 10'h010, 32'h0); #1;
    check("rml_dbg_gnt", dbg_gnt, 1);
    @(negedge clk); idle(); rst = 1'b1; #1;
    check("rml_dbg_rvalid", dbg_rvalid, 0);
    @(negedge clk); rst = 1'b0;
    set_cpu(1'b1, 1'b0, SZ_WORD, 10'h000, 32'h0);
    set_dbg(1'b1, 1'b0, SZ_WORD, 10'h000, 32'h0); #1;
    check("rml_tie_cpu", cpu_gnt, 1);
    @(negedge clk); idle(); rst = 1'b1; #1;
    check("rml2_cpu_rvalid", cpu_rvalid, 0);
    @(negedge clk); rst = 1'b0;
    set_cpu(1'b1, 1'b0, SZ_WORD, 10'h000, 32'h0);
    set_dbg(1'b1, 1'b0, SZ_WORD, 10'h000, 32'h0); #1;
    check("rml2_tie_cpu", cpu_gnt, 1);
    check("rml2_tie_dbg", dbg_gnt, 0);

    @(negedge clk); idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access controller for the single-port data memory of the pipelined RISC-V core. It shares the memory between the CPU MEM stage and a debug/loader port, so memory and register state can be loaded and inspected over a bus instead of by hierarchical preload. It also turns byte/half/word accesses into word address, write strobes and lane-replicated write data, and rejects misaligned accesses. It sits between `mem_stage` and the memory macro (`dmem_inst`).

## Interface
- `ADDR_W`, default 10: byte-address width; memory depth is 2^(ADDR_W-2) 32-bit words.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held until granted.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  32  store data, right-aligned.
- `cpu_gnt`  out  1  request accepted this cycle.
- `cpu_rvalid`  out  1  response pulse, one per granted load or error.
- `cpu_rdata`  out  32  raw memory word; 0 on error.
- `cpu_err`  out  1  misaligned or illegal access; valid with `cpu_rvalid`.
- `dbg_req`, `dbg_we`, `dbg_size`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`, `dbg_err`: same as the `cpu_*` ports, for the debug/loader port.
- `dbg_lock`  in  1  while 1, the CPU is never granted.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write enable.
- `mem_wstrb`  out  4  byte-lane write strobes.
- `mem_addr`  out  ADDR_W-2  word address, `addr[ADDR_W-1:2]`.
- `mem_wdata`  out  32  lane-replicated write data.
- `mem_rdata`  in  32  synchronous read data, valid the cycle after `mem_en`.

## Operation
- **Grant logic:** combinational from the `req` inputs and the `last_gnt` register. At most one `gnt` per cycle.
- **No contention:** a lone request is granted in the same cycle.
- **Both requesting, no lock:** the requester not equal to `last_gnt` wins. `last_gnt` updates to the granted requester on every grant.
- **Lock:** `dbg_lock`=1 forces `cpu_gnt`=0. `dbg` is still granted whenever it requests.
- **Alignment:**
  - Byte accesses are always legal.
  - Half accesses need `addr[0]`=0.
  - Word accesses need `addr[1:0]`=0.
  - Size 3 is illegal.
- **Misaligned or illegal request:** still granted, so it consumes the arbitration slot and updates `last_gnt`. It drives `mem_en`=0. It produces an error response in the next cycle for both loads and stores.
- **Write strobes:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- **Write data:**
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- **Loads:** `mem_wstrb`=0 and `mem_we`=0. The full word is returned; lane extraction and sign extension stay in `mem_stage`.
- **Memory port:** `mem_*` is combinational from the granted request. It is all-zero when nothing is granted.
- **Response state:** one registered response slot holds `rsp_valid`, `rsp_owner` and `rsp_err`.
  - It is set on the edge after a granted load or error.
  - It is cleared otherwise.
  - Stores without error generate no response.
- **Response outputs:** `rvalid` of the owner equals `rsp_valid`. `rdata` is `mem_rdata`, or 0 if `rsp_err`. The non-owner's `rvalid` and `rdata` are 0.

## Timing
- **Reset values:**
  - All `gnt`, `rvalid` and `err` outputs, and all `mem_*` outputs, are 0.
  - `rsp_valid`=0.
  - `last_gnt`=dbg, so the CPU wins the first tie.
- **Load latency:** grant in cycle N; `rvalid`/`rdata` in cycle N+1.
- **Store latency:** completes at the edge ending grant cycle N; no response.
- **Throughput:** one grant per cycle. A new grant in N+1 is allowed while the N response is returned.
- **Handshake:** requesters must hold `req` and the payload stable until `gnt`. The arbiter samples the payload only in the grant cycle.
- **Simultaneous events:**
  - A response to one requester and a grant to the other in the same cycle are independent.
  - `dbg_lock` rising while a CPU load response is pending: the response is still delivered in N+1.
- **Reset mid-operation:** the pending response is dropped (no `rvalid`) and `last_gnt` returns to dbg.

## Structure
- **Shared package `dmem_pkg`:**
  - size encodings `SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=2
  - requester IDs `REQ_CPU`=0, `REQ_DBG`=1
  - response-slot struct
- **Sub-module `dmem_lane_fmt`:** combinational; takes size, `addr[1:0]` and `wdata`; returns `wstrb`, replicated `wdata` and the misaligned flag. It is instantiated once, on the muxed winner.

## Test plan
- **Reset and idle:** `rst`=1 for 2 cycles, then idle → all outputs 0, no `mem_en`.
- **Simple store then load:** CPU word store 0xDEADBEEF to 0x010, then word load from 0x010 → store cycle has `mem_addr`=4 and `wstrb`=1111; load gives `cpu_rvalid` one cycle after grant with `cpu_rdata`=0xDEADBEEF.
- **Lanes:** byte store 0xAB to 0x013 → `wstrb`=1000, `mem_wdata`=0xABABABAB. Half store to 0x012 → `wstrb`=1100.
- **Misaligned:** CPU word load at 0x006 → `gnt`=1 and `mem_en`=0; next cycle `cpu_rvalid`=1, `cpu_err`=1, `cpu_rdata`=0.
- **Contention:**
  - Both request continuously from reset → grants alternate CPU, dbg, CPU, dbg.
  - With `dbg_lock`=1 → only dbg is granted; CPU is granted the cycle the lock drops.
- **Reset mid-load:** assert `rst` in cycle N+1 after a dbg load grant → `dbg_rvalid` stays 0, and the next tie goes to the CPU.
